// File: rtl/tdc_decoder.sv
// Thermometer-code TDC decoder: bubble correction, linear/bang-bang decode, missing-edge saturation.
// Optional window averaging is compiled in when TDC_AVG_EN is defined.
module tdc_decoder #(
   parameter int N_TAPS   = 32,
   parameter int OUT_W    = 8,
   parameter int AVG_LOG2 = 2
) (
   input  logic                    refclk,
   input  logic                    resetn,
   input  logic [N_TAPS-1:0]       taps,
   input  logic                    fb_seen,
   input  logic                    mode_bb,
   output logic signed [OUT_W-1:0] out,
   output logic                    out_valid,
   output logic                    sat
);

   localparam int RANGE = N_TAPS / 2;
   localparam logic signed [OUT_W-1:0] POS_ONE  = OUT_W'(1);
   localparam logic signed [OUT_W-1:0] POS_FULL = OUT_W'(RANGE);

   if (N_TAPS < 4 || (N_TAPS % 2) != 0) begin : g_bad_taps
      $error("tdc_decoder: N_TAPS must be even and >= 4");
   end
   if (RANGE > (2 ** (OUT_W - 1)) - 1) begin : g_bad_out_w
      $error("tdc_decoder: OUT_W too narrow to hold +/-RANGE");
   end
   if (AVG_LOG2 < 0 || AVG_LOG2 > 6) begin : g_bad_avg
      $error("tdc_decoder: AVG_LOG2 must be within 0..6");
   end

   // S1: raw capture of the sampler outputs
   logic [N_TAPS-1:0] s1_taps;
   logic              s1_fb, s1_mode, s1_valid;

   // NOTE: sequential state is always written with <= so every register samples pre-edge values.
   always_ff @(posedge refclk or negedge resetn) begin
      if (!resetn) begin
         s1_taps  <= '0;
         s1_fb    <= 1'b0;
         s1_mode  <= 1'b0;
         s1_valid <= 1'b0;
      end else begin
         s1_taps  <= taps;
         s1_fb    <= fb_seen;
         s1_mode  <= mode_bb;
         s1_valid <= 1'b1;
      end
   end

   // S2: three-tap majority removes single-tap bubbles; the end taps pass through
   logic [N_TAPS-1:0] corr;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      corr = s1_taps;
      for (int i = 1; i < N_TAPS - 1; i++) begin
         corr[i] = (s1_taps[i-1] & s1_taps[i]) |
                   (s1_taps[i]   & s1_taps[i+1]) |
                   (s1_taps[i-1] & s1_taps[i+1]);
      end
   end

   logic [N_TAPS-1:0] s2_c;
   logic              s2_fb, s2_mode, s2_valid;

   always_ff @(posedge refclk or negedge resetn) begin
      if (!resetn) begin
         s2_c     <= '0;
         s2_fb    <= 1'b0;
         s2_mode  <= 1'b0;
         s2_valid <= 1'b0;
      end else begin
         s2_c     <= corr;
         s2_fb    <= s1_fb;
         s2_mode  <= s1_mode;
         s2_valid <= s1_valid;
      end
   end

   // Decode: k is the first 0 in the corrected code, so raw = RANGE - k already spans +/-RANGE
   int                      k;
   logic signed [OUT_W-1:0] raw;
   logic                    raw_sat;

   always_comb begin
      k = N_TAPS;
      for (int i = N_TAPS - 1; i >= 0; i--) begin
         if (!s2_c[i]) k = i;
      end
      raw     = '0;
      raw_sat = 1'b0;
      if (s2_mode) begin
         raw = (s2_c[0] && s2_fb) ? -POS_ONE : POS_ONE;
      end else if (!s2_fb) begin
         raw     = POS_FULL;
         raw_sat = 1'b1;
      end else begin
         raw     = OUT_W'(RANGE - k);
         raw_sat = (k == 0) || (k == N_TAPS);
      end
   end

`ifdef TDC_AVG_EN
   localparam int ACC_W    = OUT_W + AVG_LOG2;
   localparam int CNT_W    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam int WIN_LAST = (2 ** AVG_LOG2) - 1;

   logic signed [ACC_W-1:0] acc, base_acc, sum;
   logic [CNT_W-1:0]        cnt, base_cnt;
   logic                    sat_acc, base_sat, last_mode, have_last, restart, win_done;

   // A mode change discards the partial window; the new-mode sample opens the next one
   always_comb begin
      restart  = have_last && (s2_mode != last_mode);
      base_acc = restart ? '0 : acc;
      base_cnt = restart ? '0 : cnt;
      base_sat = restart ? 1'b0 : sat_acc;
      sum      = base_acc + ACC_W'(raw);
      win_done = (base_cnt == CNT_W'(WIN_LAST));
   end

   always_ff @(posedge refclk or negedge resetn) begin
      if (!resetn) begin
         out       <= '0;
         sat       <= 1'b0;
         out_valid <= 1'b0;
         acc       <= '0;
         cnt       <= '0;
         sat_acc   <= 1'b0;
         last_mode <= 1'b0;
         have_last <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (s2_valid) begin
            last_mode <= s2_mode;
            have_last <= 1'b1;
            if (win_done) begin
               out       <= OUT_W'(sum >>> AVG_LOG2);
               sat       <= base_sat | raw_sat;
               out_valid <= 1'b1;
               acc       <= '0;
               cnt       <= '0;
               sat_acc   <= 1'b0;
            end else begin
               acc     <= sum;
               cnt     <= base_cnt + CNT_W'(1);
               sat_acc <= base_sat | raw_sat;
            end
         end
      end
   end
`else
   always_ff @(posedge refclk or negedge resetn) begin
      if (!resetn) begin
         out       <= '0;
         sat       <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= s2_valid;
         if (s2_valid) begin
            out <= raw;
            sat <= raw_sat;
         end
      end
   end
`endif

endmodule

// File: tb/tb_tdc_decoder.sv
// Directed bench for tdc_decoder (N_TAPS=16): table of decode vectors plus latency, reset and
// averaging-window sequences (the latter only when TDC_AVG_EN is defined).
module tb_tdc_decoder;

   localparam int N_TAPS   = 16;
   localparam int OUT_W    = 8;
   localparam int AVG_LOG2 = 2;

   logic                    refclk = 1'b0;
   logic                    resetn = 1'b1;
   logic [N_TAPS-1:0]       taps   = '0;
   logic                    fb_seen = 1'b1;
   logic                    mode_bb = 1'b0;
   logic signed [OUT_W-1:0] out;
   logic                    out_valid;
   logic                    sat;

   int n_cmp = 0;
   int n_bad = 0;

   tdc_decoder #(.N_TAPS(N_TAPS), .OUT_W(OUT_W), .AVG_LOG2(AVG_LOG2)) dut (
      .refclk   (refclk),
      .resetn   (resetn),
      .taps     (taps),
      .fb_seen  (fb_seen),
      .mode_bb  (mode_bb),
      .out      (out),
      .out_valid(out_valid),
      .sat      (sat)
   );

   always #5 refclk = ~refclk;

   task automatic cyc();
      @(posedge refclk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_outs(input string name, input int e_out, input int e_sat, input int e_vld);
      check({name, ".out"}, int'(out), e_out);
      check({name, ".sat"}, int'(sat), e_sat);
      check({name, ".valid"}, int'(out_valid), e_vld);
   endtask

   typedef struct {
      string             name;
      logic [N_TAPS-1:0] taps;
      logic              fb;
      logic              bb;
      int                out;
      int                sat;
   } vec_t;

   vec_t vecs[13];

   // Per-edge stimulus and expectations for multi-cycle sequences
   logic [N_TAPS-1:0] s_taps[12];
   logic              s_fb[12];
   logic              s_mode[12];
   int                e_vld[12];
   int                e_out[12];
   int                e_sat[12];

   task automatic clear_seq();
      for (int i = 0; i < 12; i++) begin
         s_taps[i] = 16'h00FF;
         s_fb[i]   = 1'b1;
         s_mode[i] = 1'b0;
         e_vld[i]  = 0;
         e_out[i]  = 0;
         e_sat[i]  = 0;
      end
   endtask

   // Resets the DUT, releases it so edge 1 captures sample 0, then checks every edge
   task automatic run_seq(input string name, input int n);
      resetn = 1'b0;
      cyc();
      for (int e = 0; e < n; e++) begin
         taps    = s_taps[e];
         fb_seen = s_fb[e];
         mode_bb = s_mode[e];
         if (e == 0) resetn = 1'b1;
         cyc();
         check($sformatf("%s.valid@%0d", name, e + 1), int'(out_valid), e_vld[e]);
         if (e_vld[e] != 0) begin
            check($sformatf("%s.out@%0d", name, e + 1), int'(out), e_out[e]);
            check($sformatf("%s.sat@%0d", name, e + 1), int'(sat), e_sat[e]);
         end
      end
   endtask

   initial begin
      vecs[0]  = '{"lin_k5",        16'h001F, 1'b1, 1'b0,  3, 1};
      vecs[0].sat = 0;
      vecs[1]  = '{"lin_all_ones",  16'hFFFF, 1'b1, 1'b0, -8, 1};
      vecs[2]  = '{"lin_all_zeros", 16'h0000, 1'b1, 1'b0,  8, 1};
      vecs[3]  = '{"lin_no_edge",   16'h00FF, 1'b0, 1'b0,  8, 1};
      vecs[4]  = '{"lin_bubble_hi", 16'h0017, 1'b1, 1'b0,  4, 0};
      vecs[5]  = '{"lin_bubble_lo", 16'h00FD, 1'b1, 1'b0,  0, 0};
      vecs[6]  = '{"lin_k15",       16'h7FFF, 1'b1, 1'b0, -7, 0};
      vecs[7]  = '{"lin_k1",        16'h0001, 1'b1, 1'b0,  7, 0};
      vecs[8]  = '{"bb_early",      16'h0001, 1'b1, 1'b1, -1, 0};
      vecs[9]  = '{"bb_late",       16'h0000, 1'b1, 1'b1,  1, 0};
      vecs[10] = '{"bb_no_edge",    16'h0001, 1'b0, 1'b1,  1, 0};
      vecs[11] = '{"bb_all_ones",   16'hFFFF, 1'b1, 1'b1, -1, 0};
      vecs[12] = '{"bb_tap0_raw",   16'h0002, 1'b1, 1'b1,  1, 0};

      // Reset state
      #1 resetn = 1'b0;
      #2 check_outs("reset", 0, 0, 0);

      // Pipeline fill: edge 1 captures, first valid at edge 3
      @(posedge refclk); #1;
      taps = 16'h001F; fb_seen = 1'b1; mode_bb = 1'b0;
      resetn = 1'b1;
      cyc();
      check("fill.valid@1", int'(out_valid), 0);
      cyc();
      check("fill.valid@2", int'(out_valid), 0);
      cyc();
`ifndef TDC_AVG_EN
      check_outs("fill@3", 3, 0, 1);

      // Decode table: hold each vector for three edges so the whole pipeline carries it
      for (int v = 0; v < 13; v++) begin
         taps    = vecs[v].taps;
         fb_seen = vecs[v].fb;
         mode_bb = vecs[v].bb;
         repeat (3) cyc();
         check_outs(vecs[v].name, vecs[v].out, vecs[v].sat, 1);
      end

      // Latency: a change captured at edge E shows on out at E+2, not earlier
      taps = 16'h001F; fb_seen = 1'b1; mode_bb = 1'b0;
      repeat (3) cyc();
      taps = 16'hFFFF;
      cyc();
      check_outs("lat@E", 3, 0, 1);
      cyc();
      check_outs("lat@E+1", 3, 0, 1);
      cyc();
      check_outs("lat@E+2", -8, 1, 1);

      // Asynchronous reset clears outputs without waiting for an edge
      #2 resetn = 1'b0;
      #1 check_outs("async_reset", 0, 0, 0);
      cyc();
      resetn = 1'b1;
      cyc();
`else
      // Two back-to-back windows: (+3,+4,+4,+4) -> 3, then (-1,-1,-1,-2) -> floor(-5/4) = -2
      clear_seq();
      s_taps[0] = 16'h001F; s_taps[1] = 16'h000F; s_taps[2] = 16'h000F; s_taps[3] = 16'h000F;
      s_taps[4] = 16'h01FF; s_taps[5] = 16'h01FF; s_taps[6] = 16'h01FF; s_taps[7] = 16'h03FF;
      e_vld[5] = 1; e_out[5] = 3;
      e_vld[9] = 1; e_out[9] = -2;
      run_seq("avg", 12);

      // Reset with two samples of the next window pending
      #2 resetn = 1'b0;
      #1 check_outs("avg_async_reset", 0, 0, 0);

      // Fresh window after reset: +8 (sat), 0, 0, 0 -> out 2, sat from the OR
      clear_seq();
      s_taps[0] = 16'h0000;
      e_vld[5] = 1; e_out[5] = 2; e_sat[5] = 1;
      run_seq("avg_sat", 8);

      // Mode toggle after two linear samples restarts the window at the first bang-bang sample
      clear_seq();
      s_taps[0] = 16'h001F; s_taps[1] = 16'h001F;
      for (int i = 2; i < 12; i++) begin
         s_taps[i] = 16'h0001;
         s_mode[i] = 1'b1;
      end
      e_vld[7] = 1; e_out[7] = -1;
      run_seq("avg_mode", 8);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
